pll_clken_seq: RTL and testbench
================================

# pll_clken_seq

Clock-enable and reset sequencer that sits directly upstream of the AE350 five-output PLL wrapper. It runs on the PLL reference clock, waits for a stable PLL lock, then asserts the PLL's per-output clock enables one at a time. After a hold period it releases a shared active-high domain reset and raises `ready`. It also handles lock loss and orderly software-requested shutdown, and keeps a saturating count of lock drops for debug.

## Interface
Parameters:
- `NUM_CLK`, 5: number of clock enables driven; maps to PLL enclk0..enclk(NUM_CLK-1).
- `LOCK_WAIT`, 1024: cycles `lock_s` must stay high before the first enable.
- `STAGGER`, 16: cycles between successive enable changes, on both power-up and shutdown.
- `RST_HOLD`, 64: cycles `rst_out` stays high after the last enable rises.

Ports:
- `clkin`, in, 1: PLL reference clock (50 MHz). This is the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `pll_lock`, in, 1: PLL LOCK. Asynchronous; synchronised internally.
- `shutdown_req`, in, 1: level request to disable all clocks in an orderly way.
- `enclk`, out, NUM_CLK: per-output clock enables to the PLL; bit k drives enclk k.
- `rst_out`, out, 1: active-high reset for the downstream clock domains.
- `ready`, out, 1: all clocks enabled and reset released.
- `lock_drops`, out, 8: saturating count of lock losses seen after lock was first achieved.

## Operation
- `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. All decisions use `lock_s`.
- All outputs are registered.
- Reset values: `enclk`=0, `rst_out`=1, `ready`=0, `lock_drops`=0, state=WAIT_LOCK, counters=0.
- The counter is $clog2(max(LOCK_WAIT, STAGGER, RST_HOLD)+1) bits wide.
- The enable index is $clog2(NUM_CLK) bits wide.

States and transitions:
- WAIT_LOCK
  - Outputs: enclk=0, rst_out=1, ready=0.
  - When `lock_s`=1 and `shutdown_req`=0: go to SETTLE with counter=0.
- SETTLE
  - Counter increments each cycle.
  - When the counter reaches LOCK_WAIT-1: set enclk[0]=1, index=1, go to ENABLE.
- ENABLE
  - Every STAGGER cycles, set enclk[index]=1 and increment the index.
  - When enclk[NUM_CLK-1] is set: go to HOLD with counter=0.
- HOLD
  - After RST_HOLD cycles: rst_out=0, ready=1, go to RUN.
- RUN
  - Steady state. rst_out=0, ready=1, all enables high.
- SHUTDOWN
  - Entered when `shutdown_req`=1 in SETTLE, ENABLE, HOLD or RUN.
  - rst_out=1 and ready=0 in the same registered update as the state change.
  - Enables clear in reverse order (highest set bit first), one every STAGGER cycles. The first clear happens STAGGER cycles after entry.
  - When enclk=0: go to OFF.
- OFF
  - enclk=0, rst_out=1.
  - When `shutdown_req`=0: go to WAIT_LOCK.

Lock loss:
- `lock_s`=0 in SETTLE, ENABLE, HOLD or RUN → next cycle enclk=0, rst_out=1, ready=0, state WAIT_LOCK.
- `lock_drops` increments (saturating at 255) only when the drop occurs in ENABLE, HOLD or RUN.
- `lock_s`=0 during SHUTDOWN clears all enables immediately, goes to OFF, and does not count.

Priorities and edge cases:
- When a lock drop and `shutdown_req` occur in the same cycle, the lock drop wins.
- `shutdown_req` in WAIT_LOCK goes straight to OFF.
- NUM_CLK=1: ENABLE goes to HOLD immediately after enclk[0] is set.

## Timing
- Cycle 0 is the first `clkin` edge that samples `pll_lock`=1.
- `lock_s` is high after edge 1, SETTLE is entered at edge 2, and enclk[0] rises at edge LOCK_WAIT+2.
- enclk[k] rises at edge LOCK_WAIT+2+k·STAGGER.
- `rst_out` falls and `ready` rises together at edge LOCK_WAIT+2+(NUM_CLK-1)·STAGGER+RST_HOLD.
- Lock-drop response: 2 synchroniser cycles plus 1 register cycle, so outputs update 3 edges after `pll_lock` falls.
- Shutdown response: rst_out rises 1 edge after `shutdown_req` is sampled high. enclk[NUM_CLK-1] clears STAGGER edges later.
- `reset` is asynchronous and can arrive mid-sequence. It forces the reset values immediately, and the sequence restarts from WAIT_LOCK after release.

## Test plan
The bench uses LOCK_WAIT=8, STAGGER=4, RST_HOLD=6, NUM_CLK=5.
- Power-up: release reset, raise `pll_lock` at cycle 0 → enclk bits 0..4 rise at edges 10, 14, 18, 22, 26. rst_out falls and ready rises at edge 32. lock_drops=0.
- Early lock glitch: drop `pll_lock` for 1 cycle during SETTLE → no enable rises, lock_drops stays 0, and the full sequence restarts from the next lock.
- Lock loss in RUN: drop `pll_lock` → 3 edges later enclk=0, rst_out=1, ready=0, lock_drops=1. Re-lock repeats the power-up timing.
- Shutdown from RUN: raise `shutdown_req` → rst_out=1 after 1 edge; enclk bits 4, 3, 2, 1, 0 clear at +4, +8, +12, +16, +20 edges; state OFF. Lowering `shutdown_req` with lock high restarts the sequence.
- Simultaneous events: lock drop and `shutdown_req` in the same cycle → WAIT_LOCK, not SHUTDOWN; lock_drops increments.
- Async reset mid-ENABLE and saturation: assert `reset` between clock edges → outputs return to reset values before the next edge. Separately, force 260 lock drops → lock_drops stays at 255.

Source files
------------

// File: rtl/pll_clken_seq.sv
// pll_clken_seq
// Clock-enable and reset sequencer for the five-output PLL wrapper. It runs
// on the PLL reference clock and waits for a synchronised, stable lock. It
// then raises the per-output clock enables one at a time and, after a hold
// period, releases the downstream domain reset and raises ready. It also
// performs an orderly reverse-order shutdown on request and keeps a
// saturating count of lock losses.
//
// Ports
//   clkin        in   1        PLL reference clock, the only clock
//   reset        in   1        asynchronous active-high reset
//   pll_lock     in   1        PLL LOCK, asynchronous (2-flop synchronised)
//   shutdown_req in   1        level request for orderly clock shutdown
//   enclk        out  NUM_CLK  per-output clock enables, bit k -> enclk k
//   rst_out      out  1        active-high reset for downstream domains
//   ready        out  1        all clocks enabled and reset released
//   lock_drops   out  8        saturating count of lock losses after lock
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_LOCK  | all enables low, waiting for lock_s with no shutdown request
// SETTLE     | lock seen, counting LOCK_WAIT cycles of stable lock
// ENABLE     | raising one enable every STAGGER cycles, lowest bit first
// HOLD       | all enables high, holding rst_out for RST_HOLD cycles
// RUN        | steady state, rst_out low, ready high
// SHUTDOWN   | rst_out high, clearing enables highest first every STAGGER
// OFF        | everything off until shutdown_req drops

module pll_clken_seq #(
   parameter int NUM_CLK   = 5,
   parameter int LOCK_WAIT = 1024,
   parameter int STAGGER   = 16,
   parameter int RST_HOLD  = 64
) (
   input  logic               clkin,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               shutdown_req,
   output logic [NUM_CLK-1:0] enclk,
   output logic               rst_out,
   output logic               ready,
   output logic [7:0]         lock_drops
);

   localparam int MAX_A   = (LOCK_WAIT > STAGGER) ? LOCK_WAIT : STAGGER;
   localparam int MAX_CNT = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int IW      = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

   localparam logic [CW-1:0]      C_LOCK = CW'(LOCK_WAIT - 1);
   localparam logic [CW-1:0]      C_STAG = CW'(STAGGER - 1);
   localparam logic [CW-1:0]      C_HOLD = CW'(RST_HOLD - 1);
   localparam logic [IW-1:0]      I_LAST = IW'(NUM_CLK - 1);
   localparam logic [NUM_CLK-1:0] EN_ONE = NUM_CLK'(1);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_SETTLE,
      S_ENABLE,
      S_HOLD,
      S_RUN,
      S_SHUTDOWN,
      S_OFF
   } state_t;

   state_t             r_state;
   logic               r_sync1;
   logic               r_sync2;
   logic [CW-1:0]      r_cnt;
   logic [IW-1:0]      r_idx;
   logic [NUM_CLK-1:0] r_enclk;
   logic               r_rst_out;
   logic               r_ready;
   logic [7:0]         r_drops;

   logic w_lock_s;

   assign w_lock_s = r_sync2;

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_lock;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         r_state   <= S_WAIT_LOCK;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_enclk   <= '0;
         r_rst_out <= 1'b1;
         r_ready   <= 1'b0;
         r_drops   <= '0;
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               r_enclk   <= '0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
               if (shutdown_req) begin
                  r_state <= S_OFF;
               end else if (w_lock_s) begin
                  r_state <= S_SETTLE;
                  r_cnt   <= '0;
               end
            end

            S_SETTLE, S_ENABLE, S_HOLD, S_RUN: begin
               // Lock loss outranks a simultaneous shutdown request.
               if (!w_lock_s) begin
                  r_state   <= S_WAIT_LOCK;
                  r_cnt     <= '0;
                  r_enclk   <= '0;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
                  // A drop while still settling is treated as an unstable
                  // lock, not a loss of an established one.
                  if (r_state != S_SETTLE && r_drops != 8'hFF)
                     r_drops <= r_drops + 8'd1;
               end else if (shutdown_req) begin
                  r_state   <= S_SHUTDOWN;
                  r_cnt     <= '0;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
               end else begin
                  case (r_state)
                     S_SETTLE: begin
                        if (r_cnt == C_LOCK) begin
                           r_enclk[0] <= 1'b1;
                           r_idx      <= IW'(1);
                           r_cnt      <= '0;
                           r_state    <= (NUM_CLK == 1) ? S_HOLD : S_ENABLE;
                        end else begin
                           r_cnt <= r_cnt + CW'(1);
                        end
                     end
                     S_ENABLE: begin
                        if (r_cnt == C_STAG) begin
                           r_enclk[r_idx] <= 1'b1;
                           r_idx          <= r_idx + IW'(1);
                           r_cnt          <= '0;
                           if (r_idx == I_LAST)
                              r_state <= S_HOLD;
                        end else begin
                           r_cnt <= r_cnt + CW'(1);
                        end
                     end
                     S_HOLD: begin
                        if (r_cnt == C_HOLD) begin
                           r_rst_out <= 1'b0;
                           r_ready   <= 1'b1;
                           r_cnt     <= '0;
                           r_state   <= S_RUN;
                        end else begin
                           r_cnt <= r_cnt + CW'(1);
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end

            S_SHUTDOWN: begin
               if (!w_lock_s) begin
                  r_enclk <= '0;
                  r_state <= S_OFF;
               end else if (r_enclk == '0) begin
                  r_state <= S_OFF;
               end else if (r_cnt == C_STAG) begin
                  // Enables are always a contiguous run from bit 0, so a
                  // right shift clears the highest set bit.
                  r_enclk <= r_enclk >> 1;
                  r_cnt   <= '0;
                  if (r_enclk == EN_ONE)
                     r_state <= S_OFF;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_OFF: begin
               r_enclk   <= '0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
               if (!shutdown_req)
                  r_state <= S_WAIT_LOCK;
            end

            default: begin
               r_state <= S_WAIT_LOCK;
            end
         endcase
      end
   end

   assign enclk      = r_enclk;
   assign rst_out    = r_rst_out;
   assign ready      = r_ready;
   assign lock_drops = r_drops;

endmodule

// File: tb/tb_pll_clken_seq.sv
// Testbench for pll_clken_seq with LOCK_WAIT=8, STAGGER=4, RST_HOLD=6,
// NUM_CLK=5. Expected outputs come from closed-form edge arithmetic
// measured from the first edge that samples pll_lock high.
module tb_pll_clken_seq;

   localparam int N     = 5;
   localparam int LW    = 8;
   localparam int ST    = 4;
   localparam int RH    = 6;
   localparam int T_RDY = LW + 2 + (N - 1) * ST + RH;

   logic         clkin;
   logic         reset;
   logic         pll_lock;
   logic         shutdown_req;
   logic [N-1:0] enclk;
   logic         rst_out;
   logic         ready;
   logic [7:0]   lock_drops;

   int   nvec;
   int   nerr;
   int   exp_drops;

   pll_clken_seq #(
      .NUM_CLK  (N),
      .LOCK_WAIT(LW),
      .STAGGER  (ST),
      .RST_HOLD (RH)
   ) dut (
      .clkin       (clkin),
      .reset       (reset),
      .pll_lock    (pll_lock),
      .shutdown_req(shutdown_req),
      .enclk       (enclk),
      .rst_out     (rst_out),
      .ready       (ready),
      .lock_drops  (lock_drops)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   // {enclk, rst_out, ready} e edges after lock is first sampled high.
   function automatic logic [N+1:0] model(input int e);
      logic [N-1:0] en;
      logic         rdy;
      en = '0;
      for (int k = 0; k < N; k++)
         if (e >= LW + 2 + k * ST) en[k] = 1'b1;
      rdy = (e >= T_RDY);
      return {en, ~rdy, rdy};
   endfunction

   function automatic logic [N+9:0] obs();
      return {enclk, rst_out, ready, lock_drops};
   endfunction

   function automatic logic [N+9:0] expv(input logic [N+1:0] m, input int d);
      return {m, 8'(d)};
   endfunction

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; pll_lock = 1'b0; shutdown_req = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      exp_drops = 0;
   endtask

   task automatic test_reset();
      logic [N+9:0] want;
      reset = 1'b1; pll_lock = 1'b0; shutdown_req = 1'b0;
      #1;
      want = expv({{N{1'b0}}, 2'b10}, 0);
      nvec++;
      if (obs() !== want) begin
         nerr++;
         $display("FAIL reset_async got %h want %h", obs(), want);
      end
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL reset_idle i=%0d got %h want %h", i, obs(), want);
         end
      end
      exp_drops = 0;
   endtask

   task automatic test_powerup();
      logic [N+9:0] want;
      int idle;
      do_reset();
      idle = $urandom_range(0, 5);
      for (int i = 0; i < idle; i++) step();
      pll_lock = 1'b1;
      for (int e = 0; e <= T_RDY + 3; e++) begin
         step();
         want = expv(model(e), exp_drops);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL powerup e=%0d got %h want %h", e, obs(), want);
         end
      end
   endtask

   task automatic test_lock_glitch();
      logic [N+9:0] want;
      int d;
      do_reset();
      d = $urandom_range(1, 7);
      pll_lock = 1'b1;
      for (int e = 0; e <= d + 1 + T_RDY + 2; e++) begin
         // Lock sampled low only at edge d; sampled high again from d+1.
         if (e == d) pll_lock = 1'b0;
         if (e == d + 1) pll_lock = 1'b1;
         step();
         want = expv(model((e >= d + 1) ? e - (d + 1) : e), 0);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL glitch d=%0d e=%0d got %h want %h", d, e, obs(), want);
         end
      end
   endtask

   task automatic test_lock_loss_run();
      logic [N+9:0] want;
      int extra;
      do_reset();
      pll_lock = 1'b1;
      for (int e = 0; e <= T_RDY; e++) step();
      extra = $urandom_range(0, 6);
      for (int i = 0; i < extra; i++) step();
      pll_lock = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         if (j == 2) exp_drops = 1;
         want = (j < 2) ? expv({{N{1'b1}}, 2'b01}, 0)
                        : expv({{N{1'b0}}, 2'b10}, exp_drops);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL lockloss j=%0d got %h want %h", j, obs(), want);
         end
      end
      extra = $urandom_range(0, 3);
      for (int i = 0; i < extra; i++) step();
      pll_lock = 1'b1;
      for (int e = 0; e <= T_RDY + 2; e++) begin
         step();
         want = expv(model(e), exp_drops);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL relock e=%0d got %h want %h", e, obs(), want);
         end
      end
   endtask

   task automatic test_shutdown_run();
      logic [N+9:0] want;
      logic [N-1:0] en;
      int           extra;
      int           nset;
      do_reset();
      pll_lock = 1'b1;
      for (int e = 0; e <= T_RDY; e++) step();
      extra = $urandom_range(0, 6);
      for (int i = 0; i < extra; i++) step();
      shutdown_req = 1'b1;
      extra = $urandom_range(0, 5);
      for (int j = 0; j <= 5 * ST + extra; j++) begin
         step();
         nset = N - (j / ST);
         if (nset < 0) nset = 0;
         en = '0;
         for (int k = 0; k < nset; k++) en[k] = 1'b1;
         want = expv({en, 2'b10}, 0);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL shutdown j=%0d got %h want %h", j, obs(), want);
         end
      end
      shutdown_req = 1'b0;
      // OFF leaves at this edge; the following edge enters SETTLE, which
      // matches edge 2 of a fresh power-up.
      for (int j = 0; j <= T_RDY + 1; j++) begin
         step();
         want = expv(model(j + 1), 0);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL restart j=%0d got %h want %h", j, obs(), want);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [N+9:0] want;
      do_reset();
      pll_lock = 1'b1;
      for (int e = 0; e <= T_RDY + $urandom_range(0, 4); e++) step();
      pll_lock = 1'b0;
      step(); step();
      shutdown_req = 1'b1;
      exp_drops = 1;
      want = expv({{N{1'b0}}, 2'b10}, exp_drops);
      for (int j = 0; j < 3; j++) begin
         step();
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL simult j=%0d got %h want %h", j, obs(), want);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [N+9:0] want;
      int g;
      shutdown_req = 1'b0; pll_lock = 1'b0;
      step(); step(); step();
      g = $urandom_range(LW + 3, LW + 2 + (N - 1) * ST - 1);
      pll_lock = 1'b1;
      for (int e = 0; e <= g; e++) begin
         step();
         want = expv(model(e), exp_drops);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL pre_areset e=%0d got %h want %h", e, obs(), want);
         end
      end
      #2 reset = 1'b1;
      #1;
      exp_drops = 0;
      want = expv({{N{1'b0}}, 2'b10}, 0);
      nvec++;
      if (obs() !== want) begin
         nerr++;
         $display("FAIL areset_mid got %h want %h", obs(), want);
      end
      #1 reset = 1'b0;
      for (int e = 0; e <= T_RDY + 1; e++) begin
         step();
         want = expv(model(e), 0);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL post_areset e=%0d got %h want %h", e, obs(), want);
         end
      end
   endtask

   task automatic test_saturation();
      logic [N+9:0] want;
      int dwell;
      do_reset();
      for (int i = 0; i < 260; i++) begin
         pll_lock = 1'b1;
         dwell = $urandom_range(LW + 2, LW + 2 + 3 * ST + RH);
         for (int e = 0; e < dwell; e++) step();
         pll_lock = 1'b0;
         step(); step(); step();
         if (exp_drops < 255) exp_drops++;
         want = expv({{N{1'b0}}, 2'b10}, exp_drops);
         nvec++;
         if (obs() !== want) begin
            nerr++;
            $display("FAIL saturate i=%0d got %h want %h", i, obs(), want);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      exp_drops = 0;
      reset = 1'b1;
      pll_lock = 1'b0;
      shutdown_req = 1'b0;
      test_reset();
      test_powerup();
      test_lock_glitch();
      test_lock_loss_run();
      test_shutdown_run();
      test_simultaneous();
      test_async_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
